// File: rtl/safe_lock_ctrl_if.sv
// Keypad-to-lock-controller bundle: scanner key inputs plus lock status outputs.
// Handshake: key_validn is an active-low level held for the whole press, key_code
// is stable while it is low; there is no ready, every new falling edge is one press.
interface safe_lock_ctrl_if #(
  parameter int unsigned CODE_LEN = 4
);
  logic [3:0]            key_code;
  logic                  key_validn;
  logic                  unlocked;
  logic                  lockout;
  logic [1:0]            state;
  logic [3:0]            entry_cnt;
  logic [4*CODE_LEN-1:0] entry_buf;
  logic [3:0]            fail_cnt;
  logic                  err;

  modport master (
    output key_code, key_validn,
    input  unlocked, lockout, state, entry_cnt, entry_buf, fail_cnt, err
  );

  modport slave (
    input  key_code, key_validn,
    output unlocked, lockout, state, entry_cnt, entry_buf, fail_cnt, err
  );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Safe combination-entry state machine driven by keypad press events.
// Optional idle auto-relock in UNLOCKED is enabled by defining SAFE_LOCK_AUTO_RELOCK_EN.
module safe_lock_ctrl #(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned           MAX_TRIES      = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 500000000,
  parameter int unsigned           RELOCK_CYCLES  = 1500000000
) (
  input  logic            clk,
  input  logic            rst_n,
  safe_lock_ctrl_if.slave bus
);
  localparam int unsigned BW   = 4 * CODE_LEN;
  localparam int unsigned TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_SET_NEW  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            prev_n_q;
  logic [3:0]      entry_cnt_q, entry_cnt_d;
  logic [BW-1:0]   entry_buf_q, entry_buf_d;
  logic [BW-1:0]   code_q, code_d;
  logic [3:0]      fail_cnt_q, fail_cnt_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            press_ev;
  logic            is_digit;
  logic            full;
  logic            clr;
  logic [3:0]      fail_inc;
  logic [BW-1:0]   shifted;

  assign press_ev = prev_n_q & ~bus.key_validn;
  assign is_digit = (bus.key_code <= 4'd9);
  assign full     = (entry_cnt_q == 4'(CODE_LEN));
  assign fail_inc = fail_cnt_q + 4'd1;

`ifdef SAFE_LOCK_AUTO_RELOCK_EN
  logic [TW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d     = state_q;
    entry_cnt_d = entry_cnt_q;
    entry_buf_d = entry_buf_q;
    code_d      = code_q;
    fail_cnt_d  = fail_cnt_q;
    err_d       = 1'b0;
    timer_d     = timer_q;
    clr         = 1'b0;
    shifted     = entry_buf_q << 4;
    shifted[3:0] = bus.key_code;

    // Digits only build the buffer while a combination is being typed.
    if (press_ev && is_digit && (state_q == ST_LOCKED || state_q == ST_SET_NEW)) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        entry_buf_d = shifted;
        entry_cnt_d = entry_cnt_q + 4'd1;
      end
    end

    case (state_q)
      ST_LOCKED: begin
        if (press_ev && !is_digit) begin
          case (bus.key_code)
            4'hA: begin
              clr = 1'b1;
              if (full && entry_buf_q == code_q) begin
                state_d    = ST_UNLOCKED;
                fail_cnt_d = 4'd0;
              end else begin
                err_d = 1'b1;
                if (full) begin
                  fail_cnt_d = fail_inc;
                  if (fail_inc == 4'(MAX_TRIES)) begin
                    state_d = ST_LOCKOUT;
                    timer_d = TW'(LOCKOUT_CYCLES - 1);
                  end
                end
              end
            end
            4'hB:    clr   = 1'b1;
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_UNLOCKED: begin
        if (press_ev) begin
          if (bus.key_code == 4'hD) begin
            state_d = ST_LOCKED;
          end else if (bus.key_code == 4'hC) begin
            state_d = ST_SET_NEW;
            clr     = 1'b1;
          end
        end
      end
      ST_SET_NEW: begin
        if (press_ev && !is_digit) begin
          case (bus.key_code)
            4'hA: begin
              if (full) begin
                code_d  = entry_buf_q;
                clr     = 1'b1;
                state_d = ST_UNLOCKED;
              end else begin
                err_d = 1'b1;
              end
            end
            4'hB: begin
              clr     = 1'b1;
              state_d = ST_UNLOCKED;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      default: begin
        if (timer_q == '0) begin
          state_d    = ST_LOCKED;
          fail_cnt_d = 4'd0;
          clr        = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase

`ifdef SAFE_LOCK_AUTO_RELOCK_EN
    // Counter only runs while sitting in UNLOCKED; any other path leaves it at zero.
    idle_d = '0;
    if (state_q == ST_UNLOCKED && state_d == ST_UNLOCKED && !press_ev) begin
      if (idle_q == TW'(RELOCK_CYCLES - 1)) begin
        state_d = ST_LOCKED;
        clr     = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
`endif

    if (clr) begin
      entry_cnt_d = 4'd0;
      entry_buf_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOCKED;
      prev_n_q    <= 1'b1;
      entry_cnt_q <= 4'd0;
      entry_buf_q <= '1;
      code_q      <= DEFAULT_CODE;
      fail_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      prev_n_q    <= bus.key_validn;
      entry_cnt_q <= entry_cnt_d;
      entry_buf_q <= entry_buf_d;
      code_q      <= code_d;
      fail_cnt_q  <= fail_cnt_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
    end
  end

`ifdef SAFE_LOCK_AUTO_RELOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  assign bus.unlocked  = (state_q == ST_UNLOCKED);
  assign bus.lockout   = (state_q == ST_LOCKOUT);
  assign bus.state     = state_q;
  assign bus.entry_cnt = entry_cnt_q;
  assign bus.entry_buf = entry_buf_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl with short lockout/relock timers.
module tb_safe_lock_ctrl;
  localparam int unsigned LOCK_T  = 100;
  localparam int unsigned RELOCK_T = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   ev_cyc = 0;

  safe_lock_ctrl_if #(.CODE_LEN(4)) bus ();

  safe_lock_ctrl #(
    .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(3),
    .LOCKOUT_CYCLES(LOCK_T), .RELOCK_CYCLES(RELOCK_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One press: low for hold cycles, then one high cycle; counts err cycles seen.
  task automatic press(input logic [3:0] k, input int hold, output int nerr);
    nerr = 0;
    @(negedge clk);
    bus.key_code   = k;
    bus.key_validn = 1'b0;
    @(negedge clk);
    ev_cyc = cyc;
    if (bus.err) nerr++;
    repeat (hold - 1) begin
      @(negedge clk);
      if (bus.err) nerr++;
    end
    bus.key_validn = 1'b1;
    @(negedge clk);
    if (bus.err) nerr++;
  endtask

  task automatic keys(input string s, input int hold, output int nerr);
    int e;
    logic [7:0] c;
    logic [3:0] k;
    nerr = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      k = (c >= 8'd65) ? 4'(c - 8'd55) : 4'(c - 8'd48);
      press(k, hold, e);
      nerr += e;
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    int t0;
    bus.key_code   = 4'd0;
    bus.key_validn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_unlocked", 32'(bus.unlocked), 32'd0);
    chk("rst_lockout", 32'(bus.lockout), 32'd0);
    chk("rst_cnt", 32'(bus.entry_cnt), 32'd0);
    chk("rst_buf", 32'(bus.entry_buf), 32'hFFFF);
    chk("rst_fail", 32'(bus.fail_cnt), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;

    // Correct default code unlocks.
    for (int i = 1; i <= 4; i++) begin
      press(4'(i), 20, e);
      chk("t1_cnt", 32'(bus.entry_cnt), 32'(i));
    end
    chk("t1_buf", 32'(bus.entry_buf), 32'h1234);
    keys("A", 20, e);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_state", 32'(bus.state), 32'd1);
    chk("t1_unlocked", 32'(bus.unlocked), 32'd1);
    chk("t1_cnt0", 32'(bus.entry_cnt), 32'd0);
    chk("t1_buf0", 32'(bus.entry_buf), 32'hFFFF);
    keys("9", 3, e);
    chk("t1_digit_ign_err", 32'(e), 32'd0);
    chk("t1_digit_ign_cnt", 32'(bus.entry_cnt), 32'd0);
    keys("D", 3, e);
    chk("t1_relock", 32'(bus.state), 32'd0);

    // Three wrong codes lock out for exactly LOCK_T cycles.
    for (int r = 1; r <= 3; r++) begin
      keys("1235", 3, e);
      press(4'hA, 3, e);
      chk("t2_err", 32'(e), 32'd1);
      chk("t2_fail", 32'(bus.fail_cnt), 32'(r));
    end
    t0 = ev_cyc;
    chk("t2_state", 32'(bus.state), 32'd3);
    chk("t2_lockout", 32'(bus.lockout), 32'd1);
    keys("1234A", 2, e);
    chk("t2_ign_err", 32'(e), 32'd0);
    chk("t2_ign_cnt", 32'(bus.entry_cnt), 32'd0);
    chk("t2_ign_state", 32'(bus.state), 32'd3);
    wait_to(t0 + LOCK_T - 1);
    chk("t2_last_lockout", 32'(bus.state), 32'd3);
    @(negedge clk);
    chk("t2_exit_state", 32'(bus.state), 32'd0);
    chk("t2_exit_fail", 32'(bus.fail_cnt), 32'd0);
    chk("t2_exit_lockout", 32'(bus.lockout), 32'd0);

    // Long hold is one press; fifth digit rejected.
    press(4'd7, 1000, e);
    chk("t3_hold_err", 32'(e), 32'd0);
    chk("t3_hold_cnt", 32'(bus.entry_cnt), 32'd1);
    chk("t3_hold_buf", 32'(bus.entry_buf), 32'hFFF7);
    keys("123", 3, e);
    press(4'd9, 3, e);
    chk("t3_full_err", 32'(e), 32'd1);
    chk("t3_full_buf", 32'(bus.entry_buf), 32'h7123);
    chk("t3_full_cnt", 32'(bus.entry_cnt), 32'd4);
    keys("B", 3, e);
    chk("t3_clear_buf", 32'(bus.entry_buf), 32'hFFFF);

    // Change code to 9876.
    keys("1234A", 3, e);
    chk("t4_unlock", 32'(bus.state), 32'd1);
    keys("C", 3, e);
    chk("t4_setnew", 32'(bus.state), 32'd2);
    keys("9876A", 3, e);
    chk("t4_set_err", 32'(e), 32'd0);
    chk("t4_set_state", 32'(bus.state), 32'd1);
    keys("D", 3, e);
    chk("t4_lock", 32'(bus.state), 32'd0);
    keys("9876A", 3, e);
    chk("t4_newcode", 32'(bus.state), 32'd1);
    keys("D", 3, e);
    keys("1234A", 3, e);
    chk("t4_old_err", 32'(e), 32'd1);
    chk("t4_old_state", 32'(bus.state), 32'd0);
    chk("t4_old_fail", 32'(bus.fail_cnt), 32'd1);

    // Partial code in SET_NEW, then abort keeps stored code.
    keys("9876A", 3, e);
    chk("t5_unlock_fail", 32'(bus.fail_cnt), 32'd0);
    keys("C55A", 3, e);
    chk("t5_part_err", 32'(e), 32'd1);
    chk("t5_part_state", 32'(bus.state), 32'd2);
    chk("t5_part_cnt", 32'(bus.entry_cnt), 32'd2);
    chk("t5_part_buf", 32'(bus.entry_buf), 32'hFF55);
    keys("B", 3, e);
    chk("t5_abort_err", 32'(e), 32'd0);
    chk("t5_abort_state", 32'(bus.state), 32'd1);
    keys("D9876A", 3, e);
    chk("t5_code_kept", 32'(bus.state), 32'd1);
    keys("DC", 3, e);
    chk("t5_locked_c_err", 32'(e), 32'd1);
    keys("E", 3, e);
    chk("t5_locked_e_err", 32'(e), 32'd1);
    chk("t5_locked_state", 32'(bus.state), 32'd0);

    // Idle behaviour in UNLOCKED.
    keys("9876A", 2, e);
    t0 = ev_cyc;
`ifdef SAFE_LOCK_AUTO_RELOCK_EN
    wait_to(t0 + RELOCK_T - 1);
    chk("t6_idle_hold", 32'(bus.state), 32'd1);
    @(negedge clk);
    chk("t6_idle_relock", 32'(bus.state), 32'd0);
    keys("9876A", 2, e);
    t0 = ev_cyc;
    wait_to(t0 + 150);
    press(4'hB, 2, e);
    t0 = ev_cyc;
    wait_to(t0 + RELOCK_T - 1);
    chk("t6_restart_hold", 32'(bus.state), 32'd1);
    @(negedge clk);
    chk("t6_restart_relock", 32'(bus.state), 32'd0);
`else
    wait_to(t0 + RELOCK_T + 100);
    chk("t6_no_relock", 32'(bus.state), 32'd1);
    keys("D", 3, e);
`endif

    // Key held through reset release gives one press; code reverts to default.
    @(negedge clk);
    bus.key_code   = 4'd5;
    bus.key_validn = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_rst_state", 32'(bus.state), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_held_cnt", 32'(bus.entry_cnt), 32'd1);
    chk("t7_held_buf", 32'(bus.entry_buf), 32'hFFF5);
    bus.key_validn = 1'b1;
    @(negedge clk);
    keys("B1234A", 3, e);
    chk("t7_default_code", 32'(bus.state), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
